// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port system RAM arbiter.
package ram_arbiter_pkg;

  // Default geometry of the 32 KiB system RAM.
  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 8;

  // Requester identities, also the encoding of grant_dma.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Every transfer, read or write, walks the same four states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles the two requester handshakes and the RAM pins.
// slave: the arbiter side; master: the CPU/DMA/RAM environment side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  // Requester 0: Z80 CPU bus interface
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  // Requester 1: DMA / loader port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  // Single-port RAM pins
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_ce;
  logic              ram_rden;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Current or last owner, 0=CPU, 1=DMA
  logic              grant_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output ram_address, ram_data_in, ram_ce, ram_rden, ram_wren,
    input  ram_q,
    output grant_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  ram_address, ram_data_in, ram_ce, ram_rden, ram_wren,
    output ram_q,
    input  grant_dma
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker. The winner is combinational from the
// current requests; the priority pointer advances only when a grant is
// actually taken, so a losing requester is served at the next contest.
module ram_arb_rr
  import ram_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       pick_en,
  output logic       winner
);

  // Requester that wins a contested pick; the other one was granted last.
  logic prio;

  // Single requester wins outright; on a tie the pointer decides.
  always_comb begin
    winner = REQ_CPU;
    if (req[REQ_CPU] && req[REQ_DMA]) begin
      winner = prio;
    end else if (req[REQ_DMA]) begin
      winner = REQ_DMA;
    end
  end

  // Hand priority to the requester that did not just win.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio <= REQ_CPU;
    end else if (pick_en && (req != 2'b00)) begin
      prio <= ~winner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the Z80 CPU (requester 0)
// and the DMA/loader port (requester 1). Each transfer takes four cycles:
// IDLE (arbitrate) -> ACCESS (RAM samples) -> READ (capture q) -> DONE (ack).
// All RAM pins and handshake outputs come straight from registers.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
)(
  input  logic          clock,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);

  state_t            state;
  logic              any_req;
  logic              winner;
  logic              xfer_we;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req = bus.cpu_req | bus.dma_req;

  ram_arb_rr u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({bus.dma_req, bus.cpu_req}),
    .pick_en (state == IDLE),
    .winner  (winner)
  );

  // Route the winning requester's operands toward the RAM registers.
  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (winner == REQ_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  // Transfer sequencer; requests are only looked at in IDLE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (any_req) state <= ACCESS;
        ACCESS:  state <= READ;
        READ:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch owner and direction at the grant; later operand changes are ignored.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.grant_dma <= REQ_CPU;
      xfer_we       <= 1'b0;
    end else if ((state == IDLE) && any_req) begin
      bus.grant_dma <= winner;
      xfer_we       <= sel_we;
    end
  end

  // RAM pins: enables rise at the grant, wren drops after one cycle so a
  // write lands exactly once, ce/rden drop entering DONE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.ram_address <= '0;
      bus.ram_data_in <= '0;
      bus.ram_ce      <= 1'b0;
      bus.ram_rden    <= 1'b0;
      bus.ram_wren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.ram_address <= sel_addr;
            bus.ram_data_in <= sel_wdata;
            bus.ram_ce      <= 1'b1;
            bus.ram_rden    <= ~sel_we;
            bus.ram_wren    <= sel_we;
          end
        end
        ACCESS: begin
          bus.ram_wren <= 1'b0;
        end
        READ: begin
          bus.ram_ce   <= 1'b0;
          bus.ram_rden <= 1'b0;
        end
        DONE: begin
        end
        default: begin
          bus.ram_ce   <= 1'b0;
          bus.ram_rden <= 1'b0;
          bus.ram_wren <= 1'b0;
        end
      endcase
    end
  end

  // Acks pulse for the DONE cycle only; read data is captured from ram_q
  // while ce&rden still guarantee the bus is driven.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      if (state == READ) begin
        if (bus.grant_dma == REQ_DMA) begin
          bus.dma_ack <= 1'b1;
          if (!xfer_we) bus.dma_rdata <= bus.ram_q;
        end else begin
          bus.cpu_ack <= 1'b1;
          if (!xfer_we) bus.cpu_rdata <= bus.ram_q;
        end
      end
    end
  end

endmodule
